// File: rtl/regfile_decoded.sv
// Integer register file for the decode stage: MSB-first one-hot write decoder,
// registered read ports with optional write-to-read bypass and hardwired-zero entry 0.
module regfile_decoded #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [ADDR_W-1:0]        raddr_a,
    input  logic [ADDR_W-1:0]        raddr_b,
    output logic [DATA_W-1:0]        rdata_a,
    output logic [DATA_W-1:0]        rdata_b,
    output logic [(2**ADDR_W)-1:0]   wr_onehot
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  dec;
    logic [DEPTH-1:0]  sel;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // MSB-first decode: bit DEPTH-1-waddr is simply bit ~waddr since DEPTH is a power of two.
    always_comb begin
        dec = '0;
        if (we && !((ZERO_REG != 0) && (waddr == '0)))
            dec[~waddr] = 1'b1;
    end

    always_comb begin
        sel = '0;
        for (int k = 0; k < DEPTH; k++)
            sel[k] = dec[DEPTH-1-k];
    end

    always_comb begin
        next_a = mem[raddr_a];
        if ((ZERO_REG != 0) && (raddr_a == '0))
            next_a = '0;
        else if ((BYPASS != 0) && !clr && dec[~raddr_a])
            next_a = wdata;
    end

    always_comb begin
        next_b = mem[raddr_b];
        if ((ZERO_REG != 0) && (raddr_b == '0))
            next_b = '0;
        else if ((BYPASS != 0) && !clr && dec[~raddr_b])
            next_b = wdata;
    end

    // Clear wins over a same-cycle write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else if (clr) begin
            for (int k = 0; k < DEPTH; k++)
                mem[k] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (sel[k])
                    mem[k] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a   <= '0;
            rdata_b   <= '0;
            wr_onehot <= '0;
        end else begin
            rdata_a   <= next_a;
            rdata_b   <= next_b;
            wr_onehot <= clr ? '0 : dec;
        end
    end

endmodule

// File: tb/tb_regfile_decoded.sv
// Self-checking bench for regfile_decoded: four configurations driven in parallel and
// compared each cycle against an array-based model of the register file.
module tb_regfile_decoded;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] wdata;

    logic [31:0] rda_def, rdb_def, oh_def;
    logic [31:0] rda_nb,  rdb_nb,  oh_nb;
    logic [31:0] rda_nz,  rdb_nz,  oh_nz;
    logic [7:0]  rda_sm,  rdb_sm;
    logic [3:0]  oh_sm;

    logic [31:0] act_a  [4];
    logic [31:0] act_b  [4];
    logic [31:0] act_oh [4];

    logic [31:0] mem    [4][32];
    logic [31:0] exp_a  [4];
    logic [31:0] exp_b  [4];
    logic [31:0] exp_oh [4];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // cfg0 defaults, cfg1 no bypass, cfg2 ordinary entry 0, cfg3 small 4x8 without zero entry
    regfile_decoded dut_def (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rda_def), .rdata_b(rdb_def), .wr_onehot(oh_def));

    regfile_decoded #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rda_nb), .rdata_b(rdb_nb), .wr_onehot(oh_nb));

    regfile_decoded #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rda_nz), .rdata_b(rdb_nz), .wr_onehot(oh_nz));

    regfile_decoded #(.ADDR_W(2), .DATA_W(8), .ZERO_REG(0)) dut_sm (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr[1:0]), .wdata(wdata[7:0]),
        .raddr_a(raddr_a[1:0]), .raddr_b(raddr_b[1:0]),
        .rdata_a(rda_sm), .rdata_b(rdb_sm), .wr_onehot(oh_sm));

    assign act_a[0]  = rda_def;
    assign act_a[1]  = rda_nb;
    assign act_a[2]  = rda_nz;
    assign act_a[3]  = {24'b0, rda_sm};
    assign act_b[0]  = rdb_def;
    assign act_b[1]  = rdb_nb;
    assign act_b[2]  = rdb_nz;
    assign act_b[3]  = {24'b0, rdb_sm};
    assign act_oh[0] = oh_def;
    assign act_oh[1] = oh_nb;
    assign act_oh[2] = oh_nz;
    assign act_oh[3] = {28'b0, oh_sm};

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 32; k++) mem[c][k] = 32'h0;
            exp_a[c]  = 32'h0;
            exp_b[c]  = 32'h0;
            exp_oh[c] = 32'h0;
        end
    endtask

    // Expected results of the coming edge, computed from the current inputs.
    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            bit          zr    = (c < 2);
            bit          bp    = (c != 1);
            int          amask = (c == 3) ? 3 : 31;
            logic [31:0] dmask = (c == 3) ? 32'hFF : 32'hFFFF_FFFF;
            int          wa    = int'(waddr) & amask;
            int          ra    = int'(raddr_a) & amask;
            int          rb    = int'(raddr_b) & amask;
            logic [31:0] wd    = wdata & dmask;
            bit          wr_ok = we && !(zr && wa == 0);

            exp_oh[c] = (clr || !wr_ok) ? 32'h0 : (32'h1 << (amask - wa));
            if (zr && ra == 0)                          exp_a[c] = 32'h0;
            else if (bp && !clr && wr_ok && wa == ra)   exp_a[c] = wd;
            else                                        exp_a[c] = mem[c][ra];
            if (zr && rb == 0)                          exp_b[c] = 32'h0;
            else if (bp && !clr && wr_ok && wa == rb)   exp_b[c] = wd;
            else                                        exp_b[c] = mem[c][rb];

            if (clr)        for (int k = 0; k < 32; k++) mem[c][k] = 32'h0;
            else if (wr_ok) mem[c][wa] = wd;
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        we = 1'b1; waddr = 5'd3; wdata = 32'h5555_AAAA; raddr_a = 5'd3; raddr_b = 5'd3;
        cycle();
        wdata = 32'hDEAD_BEEF;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== 32'h0 || act_b[c] !== 32'h0 || act_oh[c] !== 32'h0)
                $display("[TB] FAIL reset_async cfg%0d: got a=%h b=%h oh=%h, want all 0", c, act_a[c], act_b[c], act_oh[c]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== 32'h0 || act_oh[c] !== 32'h0)
                $display("[TB] FAIL reset_held cfg%0d: got a=%h oh=%h, want 0", c, act_a[c], act_oh[c]);
            else n_pass++;
        end
        rst = 1'b0; we = 1'b0;
        cycle();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== 32'h0 || act_b[c] !== 32'h0)
                $display("[TB] FAIL reset_read3 cfg%0d: got a=%h b=%h, want 0", c, act_a[c], act_b[c]);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678; raddr_a = 5'd1; raddr_b = 5'd2;
        cycle();
        n_checks++;
        if (oh_def !== 32'h0400_0000)
            $display("[TB] FAIL onehot_addr5: got %h, want 04000000", oh_def);
        else n_pass++;
        we = 1'b0; raddr_a = 5'd5;
        cycle();
        n_checks++;
        if (rda_def !== 32'h1234_5678)
            $display("[TB] FAIL read_addr5: got %h, want 12345678", rda_def);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== exp_a[c] || act_b[c] !== exp_b[c] || act_oh[c] !== exp_oh[c])
                $display("[TB] FAIL write_read cfg%0d: got a=%h b=%h oh=%h, want a=%h b=%h oh=%h",
                         c, act_a[c], act_b[c], act_oh[c], exp_a[c], exp_b[c], exp_oh[c]);
            else n_pass++;
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1111_1111; raddr_a = 5'd0; raddr_b = 5'd0;
        cycle();
        wdata = 32'hA5A5_A5A5; raddr_a = 5'd7; raddr_b = 5'd7;
        cycle();
        n_checks++;
        if (rda_def !== 32'hA5A5_A5A5 || rdb_def !== 32'hA5A5_A5A5)
            $display("[TB] FAIL bypass_on: got a=%h b=%h, want a5a5a5a5", rda_def, rdb_def);
        else n_pass++;
        n_checks++;
        if (rda_nb !== 32'h1111_1111 || rdb_nb !== 32'h1111_1111)
            $display("[TB] FAIL bypass_off: got a=%h b=%h, want 11111111", rda_nb, rdb_nb);
        else n_pass++;
        we = 1'b0;
        cycle();
        n_checks++;
        if (rda_nb !== 32'hA5A5_A5A5 || rdb_nb !== 32'hA5A5_A5A5)
            $display("[TB] FAIL bypass_off_next: got a=%h b=%h, want a5a5a5a5", rda_nb, rdb_nb);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== exp_a[c] || act_b[c] !== exp_b[c])
                $display("[TB] FAIL bypass cfg%0d: got a=%h b=%h, want a=%h b=%h", c, act_a[c], act_b[c], exp_a[c], exp_b[c]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr_a = 5'd0; raddr_b = 5'd0;
        cycle();
        n_checks++;
        if (oh_def !== 32'h0 || rda_def !== 32'h0 || rdb_def !== 32'h0)
            $display("[TB] FAIL zero_write: got oh=%h a=%h b=%h, want 0", oh_def, rda_def, rdb_def);
        else n_pass++;
        n_checks++;
        if (oh_nz !== 32'h8000_0000 || rda_nz !== 32'hFFFF_FFFF)
            $display("[TB] FAIL nonzero_write: got oh=%h a=%h, want 80000000 ffffffff", oh_nz, rda_nz);
        else n_pass++;
        we = 1'b0;
        cycle();
        n_checks++;
        if (rda_def !== 32'h0 || rda_nz !== 32'hFFFF_FFFF)
            $display("[TB] FAIL zero_read: got def=%h nz=%h, want 0 ffffffff", rda_def, rda_nz);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== exp_a[c] || act_oh[c] !== exp_oh[c])
                $display("[TB] FAIL zero_reg cfg%0d: got a=%h oh=%h, want a=%h oh=%h", c, act_a[c], act_oh[c], exp_a[c], exp_oh[c]);
            else n_pass++;
        end
    endtask

    task automatic test_clear();
        we = 1'b1; raddr_a = 5'd0; raddr_b = 5'd0;
        for (int k = 1; k < 32; k++) begin
            waddr = 5'(k); wdata = 32'(k);
            cycle();
        end
        clr = 1'b1; waddr = 5'd9; wdata = 32'h99; raddr_a = 5'd9; raddr_b = 5'd9;
        cycle();
        n_checks++;
        if (rda_def !== 32'h9 || oh_def !== 32'h0)
            $display("[TB] FAIL clear_priority: got a=%h oh=%h, want 00000009 0", rda_def, oh_def);
        else n_pass++;
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (act_a[c] !== exp_a[c] || act_oh[c] !== exp_oh[c])
                $display("[TB] FAIL clear cfg%0d: got a=%h oh=%h, want a=%h oh=%h", c, act_a[c], act_oh[c], exp_a[c], exp_oh[c]);
            else n_pass++;
        end
        clr = 1'b0; we = 1'b0;
        for (int k = 0; k < 32; k++) begin
            raddr_a = 5'(k); raddr_b = 5'(31 - k);
            cycle();
            for (int c = 0; c < 4; c++) begin
                n_checks++;
                if (act_a[c] !== 32'h0 || act_b[c] !== 32'h0)
                    $display("[TB] FAIL clear_sweep cfg%0d addr%0d: got a=%h b=%h, want 0", c, k, act_a[c], act_b[c]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_small();
        logic [3:0] want;
        we = 1'b1;
        for (int a = 0; a < 4; a++) begin
            waddr = 5'(a); wdata = 32'(8'h10 + a);
            cycle();
            want = 4'b1000 >> a;
            n_checks++;
            if (oh_sm !== want)
                $display("[TB] FAIL small_onehot addr%0d: got %b, want %b", a, oh_sm, want);
            else n_pass++;
        end
        we = 1'b0;
        cycle();
        n_checks++;
        if (oh_sm !== 4'b0000)
            $display("[TB] FAIL small_idle: got %b, want 0000", oh_sm);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit narrow = ($urandom_range(0, 1) == 1);
            we      = ($urandom_range(0, 9) < 7);
            clr     = ($urandom_range(0, 29) == 0);
            waddr   = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            raddr_a = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            wdata   = $urandom;
            cycle();
            for (int c = 0; c < 4; c++) begin
                n_checks++;
                if (act_a[c] !== exp_a[c] || act_b[c] !== exp_b[c] || act_oh[c] !== exp_oh[c])
                    $display("[TB] FAIL random it%0d cfg%0d: got a=%h b=%h oh=%h, want a=%h b=%h oh=%h",
                             i, c, act_a[c], act_b[c], act_oh[c], exp_a[c], exp_b[c], exp_oh[c]);
                else n_pass++;
            end
        end
        clr = 1'b0; we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_small();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
- Parametrised register file with an internal one-hot write-address decoder, registered read ports and write-to-read bypass.
- Generalised successor of the register-file 2-to-4 write decoder: arbitrary address width, hardwired-zero entry option, synchronous clear.
- Sits in Stage2 (decode) as the integer register file feeding the operand latches.

Parameters:
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (derived, not overridable)
DATA_W, 32, entry width in bits
ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = read returns the pre-write contents

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous clear of all entries
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr_a  in  ADDR_W  read port A address
raddr_b  in  ADDR_W  read port B address
rdata_a  out  DATA_W  read port A data, registered
rdata_b  out  DATA_W  read port B data, registered
wr_onehot  out  DEPTH  registered decoded write-enable vector, MSB-first

Behaviour:
- Reset, asynchronous on rst=1: all entries 0, rdata_a=0, rdata_b=0, wr_onehot=0. Reset held mid-write means no write occurs. First valid edge is the first rising clk with rst=0.
- Decoder: combinational vector dec[DEPTH-1:0].
  - dec = 0 when we=0.
  - Otherwise exactly one bit is set, at index DEPTH-1-waddr (MSB-first: waddr=0 sets bit DEPTH-1; waddr=DEPTH-1 sets bit 0).
  - When ZERO_REG=1 and waddr=0, dec = 0.
- Write: at the rising edge, entry k <= wdata for the single k whose dec bit is set. No other entry changes.
- wr_onehot: registered; at each edge wr_onehot <= dec, or 0 when clr=1. Latency 1. Always zero or one-hot, never multi-hot.
- Clear: clr=1 at an edge zeroes all entries. clr has priority over we: the write is dropped, and wr_onehot is 0 for that cycle.
- Read: registered, latency 1. At each edge, for each port P independently:
  - rdata_P <= 0 if ZERO_REG=1 and raddr_P=0;
  - else rdata_P <= wdata if BYPASS=1, clr=0, dec bit for raddr_P set (i.e. we=1, waddr=raddr_P);
  - else rdata_P <= entry[raddr_P] as held before the edge.
- Read during clr returns the pre-clear contents, with no bypass. The next read returns 0.
- Both ports may address the same entry, with each other and with waddr. Both receive identical data.
- BYPASS=0 with a read/write hit: rdata gets the old value. The new value is visible on a read issued in the following cycle.
- Write to entry 0 with ZERO_REG=1: silently dropped. Reads of entry 0 always return 0, regardless of BYPASS.
- Addresses are always in range; there is no wrap-around case since DEPTH = 2**ADDR_W.
- No stall or handshake: a read issues every cycle.

Test Plan:
1. Reset/init (defaults): assert rst mid-operation with we=1, waddr=3, wdata=0xDEADBEEF -> rdata_a/b=0 and wr_onehot=0 immediately. After release, a read of entry 3 returns 0x00000000.
2. Write/read + decoder order (defaults): write 0x12345678 to entry 5, then read port A at 5 next cycle -> rdata_a=0x12345678 one cycle later. wr_onehot = bit 26 only (0x04000000) the cycle after the write.
3. Bypass: BYPASS=1, we=1, waddr=7, wdata=0xA5A5A5A5, raddr_a=raddr_b=7 in the same cycle, entry 7 previously 0x11111111 -> both rdata=0xA5A5A5A5 next cycle. Rerun with BYPASS=0 -> both 0x11111111, then 0xA5A5A5A5 on the following read.
4. Zero register: ZERO_REG=1, write 0xFFFFFFFF to entry 0 -> wr_onehot=0, reads of entry 0 return 0 with and without a simultaneous write. With ZERO_REG=0 -> read returns 0xFFFFFFFF and wr_onehot=0x80000000.
5. Clear priority: fill entries 1..31 with their index, then clr=1 and we=1 to entry 9 with wdata=0x99, raddr_a=9 in the same cycle -> rdata_a=0x00000009 (pre-clear, no bypass), wr_onehot=0. Sweep all addresses afterwards -> all read 0.
6. Small config (ADDR_W=2, DATA_W=8, ZERO_REG=0): write addresses 0,1,2,3 -> wr_onehot sequence 4'b1000, 4'b0100, 4'b0010, 4'b0001. we=0 -> 4'b0000.
